// File: rtl/rbb_pkg.sv
// Shared types and sizing helpers for the ping-pong result batch buffer.
package rbb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    DRAIN = 2'b10
  } rbb_drain_st_e;

  // Bank-length storage is sized for the largest supported configuration.
  // RBB_ADDR_WIDTH must not exceed RBB_LEN_W-1.
  localparam int RBB_MAX_BANKS  = 4;
  localparam int RBB_MAX_BANK_W = 2;
  localparam int RBB_LEN_W      = 17;

  typedef logic [RBB_LEN_W-1:0]        rbb_len_t;
  typedef rbb_len_t [RBB_MAX_BANKS-1:0] rbb_len_arr_t;

  function automatic int rbb_num_lines(input int addrW);
    return 1 << addrW;
  endfunction

  function automatic int rbb_bank_w(input int numBanks);
    return (numBanks > 2) ? $clog2(numBanks) : 1;
  endfunction

endpackage

// File: rtl/rbb_if.sv
// Writer and drain-side signals of rbb_pp; slave is the buffer's view.
interface rbb_if import rbb_pkg::*; #(
  parameter int RBB_ADDR_WIDTH = 6,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int NUM_BANKS      = 2
);
  localparam int BANK_W = rbb_bank_w(NUM_BANKS);

  logic                      WrEn;
  logic [RBB_ADDR_WIDTH-1:0] WrAddr;
  logic [RBB_DATA_WIDTH-1:0] WrDin;
  logic                      task_done;
  logic [RBB_ADDR_WIDTH:0]   task_len;
  logic                      Full;
  logic                      Empty;
  logic                      ReqValid;
  logic [RBB_ADDR_WIDTH-1:0] ReqLineIdx;
  logic [BANK_W-1:0]         ReqBank;
  logic [RBB_DATA_WIDTH-1:0] RdDout;
  logic                      ReqAck;

  modport master (
    output WrEn, WrAddr, WrDin, task_done, task_len, ReqAck,
    input  Full, Empty, ReqValid, ReqLineIdx, ReqBank, RdDout
  );

  modport slave (
    input  WrEn, WrAddr, WrDin, task_done, task_len, ReqAck,
    output Full, Empty, ReqValid, ReqLineIdx, ReqBank, RdDout
  );
endinterface

// File: rtl/nlb_gram_sdp.sv
// Simple dual-port RAM, one write port, registered read (1-cycle latency).
module nlb_gram_sdp #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    dout <= mem[raddr];
  end
endmodule

// File: rtl/rbb_rd_ctrl.sv
// Drain sequencer: walks the committed bank line by line on a valid/ack handshake.
module rbb_rd_ctrl import rbb_pkg::*; #(
  parameter int AW     = 6,
  parameter int BANK_W = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pendNext,
  input  rbb_len_t            curLen,
  input  logic [BANK_W-1:0]   rdBank,
  input  logic                reqAck,
  output logic [BANK_W+AW-1:0] raddr,
  output logic                reqValid,
  output logic [AW-1:0]       reqLineIdx,
  output logic                bankDone
);
  rbb_drain_st_e state;
  logic [AW-1:0] idx;
  logic          ackFire, lastLine;

  assign ackFire    = reqValid && reqAck;
  assign lastLine   = (rbb_len_t'(idx) + rbb_len_t'(1)) == curLen;
  assign bankDone   = ackFire && lastLine;
  assign reqLineIdx = idx;

  // Re-reading the current line while unacked keeps RdDout stable; the
  // ack path looks ahead one line so back-to-back acks stream.
  always_comb begin
    raddr = {rdBank, idx};
    if (state != DRAIN)  raddr = {rdBank, {AW{1'b0}}};
    else if (ackFire)    raddr = {rdBank, idx + AW'(1)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      reqValid <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (pendNext) state <= LOAD;
        LOAD: begin
          state    <= DRAIN;
          reqValid <= 1'b1;
          idx      <= '0;
        end
        DRAIN: if (ackFire) begin
          if (lastLine) begin
            reqValid <= 1'b0;
            idx      <= '0;
            state    <= pendNext ? LOAD : IDLE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/rbb_pp.sv
// Multi-bank ping-pong result batch buffer with variable batch length.
// Optional RBB_WR_GUARD_EN: drop WrEn while Full to protect the draining bank.
module rbb_pp import rbb_pkg::*; #(
  parameter int RBB_ADDR_WIDTH = 6,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int NUM_BANKS      = 2
) (
  input logic clk,
  input logic reset_n,
  rbb_if.slave bus
);
  localparam int NUM_LINES = rbb_num_lines(RBB_ADDR_WIDTH);
  localparam int BANK_W    = rbb_bank_w(NUM_BANKS);
  localparam int RAM_AW    = BANK_W + RBB_ADDR_WIDTH;
  localparam logic [RBB_ADDR_WIDTH:0] MAX_LEN = (RBB_ADDR_WIDTH+1)'(NUM_LINES);

  logic [BANK_W-1:0]         wrBank, rdBank;
  logic [BANK_W:0]           count, countNext;
  rbb_len_arr_t              lenArr;
  logic                      full, empty;
  logic                      commit, wrFire, bankDone;
  logic [RBB_ADDR_WIDTH:0]   lenClamp;
  logic [RAM_AW-1:0]         raddr;
  logic [RBB_DATA_WIDTH-1:0] ramDout;
  logic                      reqValid;
  logic [RBB_ADDR_WIDTH-1:0] reqLineIdx;
  rbb_len_t                  curLen;

  assign lenClamp = (bus.task_len > MAX_LEN) ? MAX_LEN : bus.task_len;
  assign commit   = bus.task_done && (bus.task_len != '0) && !full;
`ifdef RBB_WR_GUARD_EN
  assign wrFire   = bus.WrEn && !full;
`else
  assign wrFire   = bus.WrEn;
`endif
  assign countNext = count + (BANK_W+1)'(commit) - (BANK_W+1)'(bankDone);
  assign curLen    = lenArr[RBB_MAX_BANK_W'(rdBank)];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrBank <= '0;
      rdBank <= '0;
      count  <= '0;
      lenArr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (commit) begin
        lenArr[RBB_MAX_BANK_W'(wrBank)] <= rbb_len_t'(lenClamp);
        wrBank <= wrBank + BANK_W'(1);
      end
      if (bankDone) rdBank <= rdBank + BANK_W'(1);
      count <= countNext;
      full  <= (countNext == (BANK_W+1)'(NUM_BANKS));
      empty <= (countNext == '0);
    end
  end

  nlb_gram_sdp #(.ADDR_W(RAM_AW), .DATA_W(RBB_DATA_WIDTH)) uRam (
    .clk   (clk),
    .we    (wrFire),
    .waddr ({wrBank, bus.WrAddr}),
    .din   (bus.WrDin),
    .raddr (raddr),
    .dout  (ramDout)
  );

  // Lookahead on count lets a fresh commit start LOAD without waiting on Empty.
  rbb_rd_ctrl #(.AW(RBB_ADDR_WIDTH), .BANK_W(BANK_W)) uRd (
    .clk        (clk),
    .reset_n    (reset_n),
    .pendNext   (countNext != '0),
    .curLen     (curLen),
    .rdBank     (rdBank),
    .reqAck     (bus.ReqAck),
    .raddr      (raddr),
    .reqValid   (reqValid),
    .reqLineIdx (reqLineIdx),
    .bankDone   (bankDone)
  );

  assign bus.Full       = full;
  assign bus.Empty      = empty;
  assign bus.ReqValid   = reqValid;
  assign bus.ReqLineIdx = reqLineIdx;
  assign bus.ReqBank    = rdBank;
  assign bus.RdDout     = reqValid ? ramDout : '0;
endmodule

// File: tb/tb_rbb_pp.sv
// Randomized bench for rbb_pp against a batch-queue scoreboard.
// Build with RBB_WR_GUARD_EN defined to exercise the write guard as well.
module tb_rbb_pp;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 2;
  localparam int NL = 16;

  typedef struct {
    int          bank;
    int          idx;
    logic [DW-1:0] data;
    bit          last;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, failures = 0;
  int mCount = 0, mWr = 0, gapCnt = 0, gapLast = 0;
  logic [DW-1:0] mMem [NB][NL];
  rec_t expQ[$];

  always #5 clk = ~clk;

  rbb_if #(.RBB_ADDR_WIDTH(AW), .RBB_DATA_WIDTH(DW), .NUM_BANKS(NB)) bus ();
  rbb_pp #(.RBB_ADDR_WIDTH(AW), .RBB_DATA_WIDTH(DW), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic cycle(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                       input logic done, input logic [AW:0] len, input int ackPct);
    logic ack, mFull, wrOk;
    int n;
    mFull = (mCount == NB);
    checks += 2;
    if (bus.Full !== mFull) begin
      failures++; $display("FAIL full: got %b want %b at %0t", bus.Full, mFull, $time);
    end
    if (bus.Empty !== (mCount == 0)) begin
      failures++; $display("FAIL empty: got %b want %b at %0t", bus.Empty, (mCount == 0), $time);
    end
    if (bus.ReqValid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL stream: unexpected line bank=%0d idx=%0d at %0t", bus.ReqBank, bus.ReqLineIdx, $time);
      end else if (bus.ReqBank !== 1'(expQ[0].bank) || bus.ReqLineIdx !== AW'(expQ[0].idx) ||
                   bus.RdDout !== expQ[0].data) begin
        failures++;
        $display("FAIL stream: got bank=%0d idx=%0d data=%h want bank=%0d idx=%0d data=%h at %0t",
                 bus.ReqBank, bus.ReqLineIdx, bus.RdDout, expQ[0].bank, expQ[0].idx, expQ[0].data, $time);
      end
      if (bus.ReqLineIdx == '0 && gapCnt > 0) gapLast = gapCnt;
      gapCnt = 0;
    end else begin
      gapCnt++;
    end
    ack = ($urandom_range(99) < ackPct);
    bus.WrEn = wr; bus.WrAddr = addr; bus.WrDin = d;
    bus.task_done = done; bus.task_len = len; bus.ReqAck = ack;
    if (bus.ReqValid === 1'b1 && ack && expQ.size() > 0) begin
      if (expQ[0].last) mCount--;
      expQ.delete(0);
    end
`ifdef RBB_WR_GUARD_EN
    wrOk = wr && !mFull;
`else
    wrOk = wr;
`endif
    if (wrOk) mMem[mWr][addr] = d;
    if (done && len != '0 && !mFull) begin
      n = (int'(len) > NL) ? NL : int'(len);
      for (int j = 0; j < n; j++)
        expQ.push_back('{bank: mWr, idx: j, data: mMem[mWr][j], last: (j == n - 1)});
      mWr = (mWr + 1) % NB;
      mCount++;
    end
    @(posedge clk); #1;
  endtask

  task automatic write_batch(input int nLines, input bit incr, input int len, input int ackPct);
    for (int i = 0; i < nLines; i++)
      cycle(1'b1, AW'(i), incr ? DW'(i * 3) : DW'($urandom()), 1'b0, '0, ackPct);
    cycle(1'b0, '0, '0, 1'b1, (AW+1)'(len), ackPct);
  endtask

  task automatic drain_all(input int ackPct, input int bound, input string name);
    for (int k = 0; k < bound && expQ.size() != 0; k++) cycle(1'b0, '0, '0, 1'b0, '0, ackPct);
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("FAIL %s: drain timeout, lines left %0d want 0", name, expQ.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.Full, bus.Empty, bus.ReqValid, bus.ReqLineIdx, bus.ReqBank, bus.RdDout} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset: full=%b empty=%b vld=%b idx=%0d bank=%0d dout=%h", bus.Full, bus.Empty,
               bus.ReqValid, bus.ReqLineIdx, bus.ReqBank, bus.RdDout);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    write_batch(16, 1'b1, 16, 100);
    checks++;
    if (bus.ReqValid !== 1'b0 || bus.Empty !== 1'b0) begin
      failures++; $display("FAIL basic_t1: vld=%b empty=%b want vld=0 empty=0", bus.ReqValid, bus.Empty);
    end
    cycle(1'b0, '0, '0, 1'b0, '0, 100);
    checks++;
    if (bus.ReqValid !== 1'b1 || bus.ReqLineIdx !== 4'd0 || bus.RdDout !== 32'd0) begin
      failures++;
      $display("FAIL basic_t2: vld=%b idx=%0d dout=%h want vld=1 idx=0 dout=0", bus.ReqValid, bus.ReqLineIdx, bus.RdDout);
    end
    repeat (16) cycle(1'b0, '0, '0, 1'b0, '0, 100);
    checks++;
    if (expQ.size() != 0 || bus.Empty !== 1'b1) begin
      failures++; $display("FAIL basic_rate: left=%0d empty=%b want left=0 empty=1", expQ.size(), bus.Empty);
    end
  endtask

  task automatic test_pingpong();
    write_batch(5, 1'b0, 5, 0);
    write_batch(16, 1'b0, 16, 0);
    checks++;
    if (bus.Full !== 1'b1) begin
      failures++; $display("FAIL pingpong_full: got %b want 1", bus.Full);
    end
    drain_all(100, 100, "pingpong");
    checks++;
    if (gapLast != 1) begin
      failures++; $display("FAIL pingpong_bubble: gap=%0d want 1", gapLast);
    end
  endtask

  task automatic test_random_ack();
    int lens[5] = '{1, 16, 20, 0, 0};
    lens[3] = $urandom_range(1, 16);
    lens[4] = $urandom_range(1, 16);
    foreach (lens[b]) begin
      for (int k = 0; k < 300 && mCount == NB; k++) cycle(1'b0, '0, '0, 1'b0, '0, 50);
      write_batch((lens[b] > NL) ? NL : lens[b], 1'b0, lens[b], 50);
    end
    drain_all(50, 1000, "random_ack");
  endtask

  task automatic test_coincident();
    bit hit = 0;
    write_batch(3, 1'b0, 3, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i), DW'($urandom()), 1'b0, '0, 0);
    for (int k = 0; k < 50; k++) begin
      if (bus.ReqValid === 1'b1 && expQ.size() > 0 && expQ[0].last) begin hit = 1; break; end
      cycle(1'b0, '0, '0, 1'b0, '0, 100);
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL coincident_setup: last line reached=%0d want 1", hit);
    end
    cycle(1'b0, '0, '0, 1'b1, 5'd4, 100);
    checks++;
    if (bus.Empty !== 1'b0 || bus.Full !== 1'b0) begin
      failures++; $display("FAIL coincident_count: empty=%b full=%b want 0 0", bus.Empty, bus.Full);
    end
    drain_all(100, 100, "coincident");
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    write_batch(16, 1'b0, 16, 0);
    for (int k = 0; k < 60; k++) begin
      if (bus.ReqValid === 1'b1 && bus.ReqLineIdx === 4'd7) begin hit = 1; break; end
      cycle(1'b0, '0, '0, 1'b0, '0, 100);
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL reset_mid_setup: line 7 reached=%0d want 1", hit);
    end
    bus.ReqAck = 1'b0; bus.WrEn = 1'b0; bus.task_done = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.Full, bus.Empty, bus.ReqValid, bus.ReqLineIdx, bus.ReqBank, bus.RdDout} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_mid: full=%b empty=%b vld=%b idx=%0d bank=%0d dout=%h", bus.Full, bus.Empty,
               bus.ReqValid, bus.ReqLineIdx, bus.ReqBank, bus.RdDout);
    end
    expQ.delete(); mCount = 0; mWr = 0; gapCnt = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    write_batch(4, 1'b1, 4, 100);
    drain_all(100, 50, "reset_mid_restart");
  endtask

  task automatic test_ignored();
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 0);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, '0, 0);
    checks++;
    if (bus.Empty !== 1'b1 || bus.ReqValid !== 1'b0) begin
      failures++; $display("FAIL len_zero: empty=%b vld=%b want 1 0", bus.Empty, bus.ReqValid);
    end
    write_batch(2, 1'b0, 2, 0);
    write_batch(2, 1'b0, 2, 0);
    cycle(1'b0, '0, '0, 1'b1, 5'd3, 0);
`ifdef RBB_WR_GUARD_EN
    for (int i = 0; i < 2; i++) cycle(1'b1, AW'(i), 32'hDEAD_BEEF, 1'b0, '0, 0);
`endif
    drain_all(100, 100, "full_ignore");
    repeat (4) cycle(1'b0, '0, '0, 1'b0, '0, 100);
    checks++;
    if (bus.Empty !== 1'b1) begin
      failures++; $display("FAIL full_ignore_empty: got %b want 1", bus.Empty);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrDin = '0;
    bus.task_done = 1'b0; bus.task_len = '0; bus.ReqAck = 1'b0;
    test_reset();
    test_basic();
    test_pingpong();
    test_random_ack();
    test_coincident();
    test_reset_mid();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rbb_pp.md
Name: rbb_pp

Overview:
- Multi-bank (ping-pong) result batch buffer between one PE array and the host write-back path.
- The PE array writes batch N+1 into a free bank while batch N drains line-by-line through a valid/ack request interface.
- Batches have a variable length given at commit time.
- Generalises the single-bank, fixed-length result buffer in depth, bank count and batch length.

Parameters:
- RBB_ADDR_WIDTH, 6, log2 of lines per bank; NUM_LINES = 2**RBB_ADDR_WIDTH.
- RBB_DATA_WIDTH, 512, bits per line.
- NUM_BANKS, 2, bank count; power of two, 2..4. BANK_W = max(1, clog2(NUM_BANKS)).

Ports:
- clk, in, 1, core clock.
- reset_n, in, 1, reset. One clock; reset is asynchronous and active-low.
- WrEn, in, 1, write line into the current write bank.
- WrAddr, in, RBB_ADDR_WIDTH, line index within the write bank.
- WrDin, in, RBB_DATA_WIDTH, write data.
- task_done, in, 1, 1-cycle pulse: commit the current write bank.
- task_len, in, RBB_ADDR_WIDTH+1, valid lines in the committed batch, 1..NUM_LINES; sampled with task_done.
- Full, out, 1, no free bank; writer must stall.
- Empty, out, 1, no committed bank.
- ReqValid, out, 1, ReqLineIdx/ReqBank/RdDout valid.
- ReqLineIdx, out, RBB_ADDR_WIDTH, line index being presented.
- ReqBank, out, BANK_W, bank being drained.
- RdDout, out, RBB_DATA_WIDTH, line data.
- ReqAck, in, 1, consumer accepts the current line.

Behaviour:
- Reset: Full=0, Empty=1, ReqValid=0, ReqLineIdx=0, ReqBank=0, RdDout=0. All banks free, wr_bank=rd_bank=0, count=0. RAM contents are not cleared.
- Reset mid-drain or mid-write abandons all batches; no partial state survives.
- Bank state:
  - wr_bank, rd_bank: mod-NUM_BANKS pointers.
  - count: 0..NUM_BANKS committed banks.
  - len[bank]: stored task_len per bank.
  - Full = (count == NUM_BANKS). Empty = (count == 0). Both are registered.
- Storage: one SDP RAM, depth NUM_BANKS*NUM_LINES, write address {wr_bank, WrAddr}, 1-cycle read latency.
- Commit:
  - task_done with task_len != 0 and !Full stores len[wr_bank], advances wr_bank and increments count on the next edge.
  - task_done with task_len == 0 is ignored.
  - A task_len value above NUM_LINES is clamped to NUM_LINES.
- Drain FSM (IDLE, LOAD, DRAIN):
  - IDLE -> LOAD when !Empty.
  - LOAD: RAM raddr = {rd_bank, 0}. Next state DRAIN, with ReqValid=1, ReqLineIdx=0, RdDout=line 0.
  - DRAIN: outputs hold stable until ReqAck.
    - ReqAck on a non-last line: raddr = idx+1 driven combinationally, so the next line appears the following cycle. Back-to-back acks give 1 line/cycle.
    - ReqAck on line len[rd_bank]-1: frees the bank, advances rd_bank, decrements count, then goes to LOAD if count-1 > 0, else IDLE.
    - One bubble cycle (ReqValid=0) separates batches.
  - ReqAck while ReqValid=0 is ignored.
- Latency: task_done at cycle t gives Empty=0 at t+1 and ReqValid=1 with line 0 at t+2.
- Simultaneous events:
  - Commit and last-line ack in the same cycle: net count unchanged, both pointers advance.
  - Full falls the cycle after the last-line ack.
  - A write to the bank being drained is impossible unless Full is violated.

Optional Feature:
- RBB_WR_GUARD_EN.
- Defined: WrEn and task_done while Full are dropped (no RAM write, no commit), protecting the draining bank.
- Undefined: WrEn writes unconditionally. task_done while Full is still ignored. The writer is responsible for honouring Full.

Decomposition:
- Package rbb_pkg:
  - drain FSM state enum (IDLE=2'b00, LOAD=2'b01, DRAIN=2'b10);
  - NUM_LINES/BANK_W derivation functions;
  - the bank-length array type.
- Storage uses the existing nlb_gram_sdp (1-cycle read mode).
- One natural sub-module, rbb_rd_ctrl: drain FSM, line counter and read-address mux. The top keeps the bank bookkeeping.

Test Plan:
1. Reset, write 16 lines (ADDR_WIDTH=4, DATA=32, data=idx*3), task_done len=16, ReqAck held high -> ReqValid 2 cycles after commit; lines 0..15 on 16 consecutive cycles with RdDout=idx*3; Empty=1 after.
2. Commit len=5 to bank 0, then len=16 to bank 1 while bank 0 drains -> Full=1 after the second commit; 5 lines from bank 0, one bubble, 16 from bank 1; Full=0 the cycle after bank 0's last ack.
3. Random ReqAck (50%) -> ReqLineIdx/RdDout stable while unacked; no line skipped or duplicated.
4. Last-line ack coincident with task_done -> count unchanged, both pointers advance, no lost batch.
5. Assert reset_n low mid-DRAIN (line 7 of 16) -> outputs reach reset values asynchronously; next batch starts at bank 0, line 0.
6. RBB_WR_GUARD_EN defined: WrEn while Full -> draining bank data unchanged; task_done len=0 -> no commit, Empty stays 1.
